i2c_master_arbiter: RTL and testbench

- Shares one i2c_master_top instance between two requesters (req0, req1).
- Arbitrates round-robin, latches the winner's command and drives the master's enable, addr_rw and repeat-start inputs.
- Counts transferred bytes, terminates the transaction, then reports completion or error back to the winner.
- Sits between the CPU/DMA command ports and i2c_master_top.

---
 rtl/i2c_master_arbiter_if.sv | 28 ++
 rtl/i2c_master_arbiter.sv | 137 +++++++++++++
 tb/tb_i2c_master_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_arbiter_if.sv
// Command/status bus between the arbiter and the shared i2c_master_top.
// Field names follow the arbiter-side port names of the master connection.
interface i2c_master_arbiter_if;
    logic       master_enable_o;
    logic [7:0] master_addr_rw_o;
    logic       master_repeat_start_o;
    logic       master_busy_i;
    logic       master_byte_done_i;
    logic       master_nack_i;

    modport master (
        output master_enable_o,
        output master_addr_rw_o,
        output master_repeat_start_o,
        input  master_busy_i,
        input  master_byte_done_i,
        input  master_nack_i
    );

    modport slave (
        input  master_enable_o,
        input  master_addr_rw_o,
        input  master_repeat_start_o,
        output master_busy_i,
        output master_byte_done_i,
        output master_nack_i
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master between two requesters,
// with repeated-start bus locking, byte counting and transaction timeout.
module i2c_master_arbiter #(
    parameter int TO_W = 16
) (
    input  logic                 i2c_core_clock_i,
    input  logic                 reset_bit_i,
    input  logic                 req0_i,
    input  logic [7:0]           req0_addr_rw_i,
    input  logic [7:0]           req0_nbytes_i,
    input  logic                 req0_repeat_start_i,
    input  logic                 req1_i,
    input  logic [7:0]           req1_addr_rw_i,
    input  logic [7:0]           req1_nbytes_i,
    input  logic                 req1_repeat_start_i,
    output logic                 gnt0_o,
    output logic                 gnt1_o,
    output logic                 done0_o,
    output logic                 done1_o,
    output logic [1:0]           err_o,
    input  logic [TO_W-1:0]      timeout_limit_i,
    i2c_master_arbiter_if.master m
);
    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DRAIN, DONE} state_t;

    state_t         state, state_nx;
    logic           win, rr_ptr, lock, lock_id;
    logic [7:0]     addr_l, nbytes_l, byte_cnt, cnt_inc;
    logic           rs_l;
    logic [1:0]     err_l;
    logic [TO_W-1:0] to_cnt;
    logic           lock_req, sel_valid, sel, tmo, active, owned, en;

    assign lock_req  = lock_id ? req1_i : req0_i;
    assign sel_valid = req0_i | req1_i;

    // Lock beats round-robin; rr_ptr only breaks a genuine tie.
    always_comb begin
        sel = req1_i;
        if (lock && lock_req)
            sel = lock_id;
        else if (req0_i && req1_i)
            sel = rr_ptr;
    end

    assign active = (state == ARM) || (state == RUN) || (state == DRAIN);
    assign owned  = active || (state == DONE);
    assign tmo    = active && (timeout_limit_i != '0) &&
                    (to_cnt == timeout_limit_i - TO_W'(1));

    assign cnt_inc = (m.master_byte_done_i && byte_cnt != 8'hFF) ?
                     byte_cnt + 8'd1 : byte_cnt;

    always_comb begin
        state_nx = state;
        en       = 1'b0;
        unique case (state)
            IDLE:  if (sel_valid) state_nx = LOAD;
            LOAD:  state_nx = ARM;
            ARM: begin
                if (tmo)
                    state_nx = DONE;
                else if (m.master_nack_i)
                    state_nx = DRAIN;
                else begin
                    en = 1'b1;
                    if (m.master_busy_i) state_nx = RUN;
                end
            end
            RUN: begin
                if (tmo)
                    state_nx = DONE;
                else if (m.master_nack_i || cnt_inc == nbytes_l)
                    state_nx = DRAIN;
                else
                    en = 1'b1;
            end
            DRAIN: if (tmo || !m.master_busy_i) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            state    <= IDLE;
            win      <= 1'b0;
            rr_ptr   <= 1'b0;
            lock     <= 1'b0;
            lock_id  <= 1'b0;
            addr_l   <= '0;
            nbytes_l <= '0;
            rs_l     <= 1'b0;
            byte_cnt <= '0;
            err_l    <= '0;
            to_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (lock && !lock_req) lock <= 1'b0;
                if (sel_valid) win <= sel;
            end
            if (state == LOAD) begin
                addr_l   <= win ? req1_addr_rw_i : req0_addr_rw_i;
                nbytes_l <= win ? req1_nbytes_i : req0_nbytes_i;
                rs_l     <= win ? req1_repeat_start_i : req0_repeat_start_i;
                byte_cnt <= '0;
                err_l    <= '0;
                to_cnt   <= '0;
            end
            if (active) begin
                to_cnt <= to_cnt + TO_W'(1);
                if (tmo)
                    err_l <= 2'b10;
                else if (state != DRAIN && m.master_nack_i)
                    err_l <= 2'b01;
                else if (state != DRAIN)
                    byte_cnt <= cnt_inc;
            end
            if (state == DONE) begin
                rr_ptr  <= ~win;
                lock    <= rs_l;
                lock_id <= win;
            end
        end
    end

    assign gnt0_o  = owned && !win;
    assign gnt1_o  = owned && win;
    assign done0_o = (state == DONE) && !win;
    assign done1_o = (state == DONE) && win;
    assign err_o   = (state == DONE) ? err_l : 2'b00;

    assign m.master_enable_o       = en;
    assign m.master_addr_rw_o      = owned ? addr_l : 8'h00;
    assign m.master_repeat_start_o = owned && rs_l;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench: table of arbitration transactions plus hand-written
// timeout, no-timeout and mid-transaction reset sequences.
module tb_i2c_master_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, req1 = 0, rs0 = 0, rs1 = 0;
    logic [7:0]  a0 = 0, a1 = 0, nb0 = 0, nb1 = 0;
    logic        gnt0, gnt1, done0, done1;
    logic [1:0]  err;
    logic [15:0] limit = 16'd1000;
    int          total = 0, bad = 0;

    i2c_master_arbiter_if bus();

    i2c_master_arbiter #(.TO_W(16)) dut (
        .i2c_core_clock_i    (clk),
        .reset_bit_i         (rst),
        .req0_i              (req0),
        .req0_addr_rw_i      (a0),
        .req0_nbytes_i       (nb0),
        .req0_repeat_start_i (rs0),
        .req1_i              (req1),
        .req1_addr_rw_i      (a1),
        .req1_nbytes_i       (nb1),
        .req1_repeat_start_i (rs1),
        .gnt0_o              (gnt0),
        .gnt1_o              (gnt1),
        .done0_o             (done0),
        .done1_o             (done1),
        .err_o               (err),
        .timeout_limit_i     (limit),
        .m                   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r0_on, r1_on, keep, nack;
        logic [7:0] a0, a1, nb;
        logic       rs0, rs1;
        int         lat;
        logic       exp_win;
        logic [7:0] exp_addr;
        logic       exp_rs;
        logic [1:0] exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(output bit got, output int n);
        got = 0;
        n   = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            #1;
            n++;
            if (gnt0 || gnt1) got = 1;
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_gnt"}, {gnt0, gnt1}, 0);
        chk({name, "_done"}, {done0, done1}, 0);
        chk({name, "_err"}, err, 0);
        chk({name, "_en"}, bus.master_enable_o, 0);
        chk({name, "_addr"}, bus.master_addr_rw_o, 0);
        chk({name, "_rs"}, bus.master_repeat_start_o, 0);
    endtask

    task automatic serve(input vec_t v);
        bit got;
        int n;
        a0 = v.a0; a1 = v.a1; nb0 = v.nb; nb1 = v.nb;
        rs0 = v.rs0; rs1 = v.rs1;
        if (v.r0_on) req0 = 1;
        if (v.r1_on) req1 = 1;
        wait_gnt(got, n);
        chk("grant_seen", got, 1);
        if (!got) return;
        chk("latency", n, v.lat);
        chk("winner", gnt1, v.exp_win);
        chk("loser_gnt", v.exp_win ? gnt0 : gnt1, 0);
        chk("addr_rw", bus.master_addr_rw_o, v.exp_addr);
        chk("rep_start", bus.master_repeat_start_o, v.exp_rs);
        chk("arm_en", bus.master_enable_o, 1);
        bus.master_busy_i = 1;
        @(negedge clk);
        if (v.nack) begin
            bus.master_nack_i = 1;
            bus.master_byte_done_i = (v.nb != 0);
            #1 chk("nack_en", bus.master_enable_o, 0);
            @(negedge clk);
            bus.master_nack_i = 0;
            bus.master_byte_done_i = 0;
        end else if (v.nb == 0) begin
            #1 chk("addr_only_en", bus.master_enable_o, 0);
            @(negedge clk);
        end else begin
            for (int k = 1; k <= int'(v.nb); k++) begin
                bus.master_byte_done_i = 1;
                #1 chk("byte_en", bus.master_enable_o, k < int'(v.nb));
                @(negedge clk);
                bus.master_byte_done_i = 0;
                if (k < int'(v.nb)) begin
                    #1 chk("gap_en", bus.master_enable_o, 1);
                    @(negedge clk);
                end
            end
        end
        #1;
        chk("drain_done", {done0, done1}, 0);
        chk("drain_en", bus.master_enable_o, 0);
        bus.master_busy_i = 0;
        @(negedge clk);
        #1;
        chk("done", v.exp_win ? done1 : done0, 1);
        chk("err", err, v.exp_err);
        chk("gnt_in_done", v.exp_win ? gnt1 : gnt0, 1);
        if (!v.keep) begin
            if (v.exp_win) req1 = 0;
            else req0 = 0;
        end
    endtask

    function automatic vec_t mk(logic r0, logic r1, logic [7:0] x0,
                                logic [7:0] x1, logic [7:0] nb, logic s1,
                                logic kp, logic nk, int lat, logic w,
                                logic [7:0] ea, logic ers, logic [1:0] ee);
        vec_t v;
        v.r0_on = r0; v.r1_on = r1; v.a0 = x0; v.a1 = x1; v.nb = nb;
        v.rs0 = 0; v.rs1 = s1; v.keep = kp; v.nack = nk; v.lat = lat;
        v.exp_win = w; v.exp_addr = ea; v.exp_rs = ers; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        bit got;
        int n, j;
        logic en98, en99, seen_done;

        vecs[0]  = mk(1, 0, 8'hA0, 8'h00, 3, 0, 0, 0, 2, 0, 8'hA0, 0, 2'b00);
        vecs[1]  = mk(0, 1, 8'h00, 8'h72, 2, 0, 0, 0, 3, 1, 8'h72, 0, 2'b00);
        vecs[2]  = mk(1, 1, 8'h42, 8'h85, 1, 0, 0, 0, 3, 0, 8'h42, 0, 2'b00);
        vecs[3]  = mk(0, 0, 8'h42, 8'h85, 1, 0, 0, 0, 3, 1, 8'h85, 0, 2'b00);
        vecs[4]  = mk(1, 0, 8'h10, 8'h00, 1, 0, 0, 0, 3, 0, 8'h10, 0, 2'b00);
        vecs[5]  = mk(1, 1, 8'h20, 8'h21, 1, 0, 0, 0, 3, 1, 8'h21, 0, 2'b00);
        vecs[6]  = mk(0, 0, 8'h20, 8'h21, 1, 0, 0, 0, 3, 0, 8'h20, 0, 2'b00);
        vecs[7]  = mk(1, 1, 8'h44, 8'h31, 2, 1, 1, 0, 3, 1, 8'h31, 1, 2'b00);
        vecs[8]  = mk(0, 0, 8'h44, 8'h31, 2, 1, 0, 0, 3, 1, 8'h31, 1, 2'b00);
        vecs[9]  = mk(0, 0, 8'h44, 8'h31, 2, 0, 0, 0, 3, 0, 8'h44, 0, 2'b00);
        vecs[10] = mk(0, 1, 8'h00, 8'h68, 0, 0, 0, 1, 3, 1, 8'h68, 0, 2'b01);
        vecs[11] = mk(1, 0, 8'h90, 8'h00, 2, 0, 0, 1, 3, 0, 8'h90, 0, 2'b01);
        vecs[12] = mk(0, 1, 8'h00, 8'h3C, 0, 0, 0, 0, 3, 1, 8'h3C, 0, 2'b00);

        bus.master_busy_i = 0;
        bus.master_byte_done_i = 0;
        bus.master_nack_i = 0;
        repeat (3) @(negedge clk);
        #1 chk_idle_outputs("reset");
        rst = 0;

        foreach (vecs[i]) serve(vecs[i]);

        // Busy never falls: timeout must end the transaction.
        limit = 16'd100;
        a0 = 8'h5A; nb0 = 1; rs0 = 0; req0 = 1;
        wait_gnt(got, n);
        chk("to_grant", gnt0, 1);
        bus.master_busy_i = 1;
        j = 0; en98 = 0; en99 = 1; seen_done = 0;
        while (!seen_done && j < 150) begin
            @(negedge clk);
            #1;
            j++;
            if (j == 98) en98 = bus.master_enable_o;
            if (j == 99) en99 = bus.master_enable_o;
            if (done0) seen_done = 1;
        end
        chk("to_done_seen", seen_done, 1);
        chk("to_cycles", j, 100);
        chk("to_err", err, 2'b10);
        chk("to_en_before", en98, 1);
        chk("to_en_cleared", en99, 0);
        req0 = 0;
        @(negedge clk);
        #1 chk("to_gnt_drop", gnt0, 0);
        bus.master_busy_i = 0;

        // Timeout disabled: arbiter must wait.
        limit = 16'd0;
        a1 = 8'h7E; nb1 = 1; rs1 = 0; req1 = 1;
        wait_gnt(got, n);
        chk("nto_grant", gnt1, 1);
        bus.master_busy_i = 1;
        seen_done = 0;
        repeat (300) begin
            @(negedge clk);
            #1 if (done1) seen_done = 1;
        end
        chk("nto_no_done", seen_done, 0);
        chk("nto_gnt_held", gnt1, 1);
        chk("nto_en_held", bus.master_enable_o, 1);
        bus.master_byte_done_i = 1;
        #1 chk("nto_en_drop", bus.master_enable_o, 0);
        @(negedge clk);
        bus.master_byte_done_i = 0;
        bus.master_busy_i = 0;
        @(negedge clk);
        #1;
        chk("nto_done", done1, 1);
        chk("nto_err", err, 2'b00);
        req1 = 0;

        serve(mk(1, 0, 8'hB4, 8'h00, 1, 0, 0, 0, 3, 0, 8'hB4, 0, 2'b00));

        // Reset in RUN with rr_ptr pointing at req1.
        a1 = 8'hC2; nb1 = 3; req1 = 1;
        wait_gnt(got, n);
        chk("rst_grant", gnt1, 1);
        bus.master_busy_i = 1;
        @(negedge clk);
        bus.master_byte_done_i = 1;
        @(negedge clk);
        bus.master_byte_done_i = 0;
        rst = 1;
        @(negedge clk);
        #1 chk_idle_outputs("midrst");
        rst = 0;
        bus.master_busy_i = 0;
        serve(mk(1, 1, 8'hA0, 8'hC2, 3, 0, 0, 0, 2, 0, 8'hA0, 0, 2'b00));
        serve(mk(0, 0, 8'hA0, 8'hC2, 3, 0, 0, 0, 3, 1, 8'hC2, 0, 2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
